// File: rtl/nibble_pkg.sv
// nibble_pkg: shared widths and FSM state type for the nibble unpacker.
package nibble_pkg;
    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;
    typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_t;
endpackage

// File: rtl/nibble_cnt.sv
// nibble_cnt: wrapping counter with synchronous active-high reset and increment enable.
module nibble_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = en ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk)
        cnt_q <= reset ? '0 : cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/nibble_unpacker.sv
// nibble_unpacker: byte-to-nibble stream unpacker with per-byte nibble order.
// Optional registered nibble parity output when NIBBLE_PARITY_EN is defined.
module nibble_unpacker
    import nibble_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   in,
    input  logic                swap_en,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NIBBLE_W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
`ifdef NIBBLE_PARITY_EN
    output logic                out_par,
`endif
    output logic [CNT_W-1:0]    byte_cnt
);
    state_t              state_q, state_d;
    logic [NIBBLE_W-1:0] out_q, out_d;
    logic [NIBBLE_W-1:0] sec_q, sec_d;
    logic                accept;
    logic                done;

    assign in_ready = !reset && (state_q == EMPTY || (state_q == SECOND && out_ready));
    assign accept   = in_valid && in_ready;
    assign done     = state_q == SECOND && out_ready;

    // Only the second nibble needs keeping; the first goes straight into out_q.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sec_d   = sec_q;
        if (accept) begin
            state_d = FIRST;
            out_d   = swap_en ? in[3:0] : in[7:4];
            sec_d   = swap_en ? in[7:4] : in[3:0];
        end else if (state_q == FIRST && out_ready) begin
            state_d = SECOND;
            out_d   = sec_q;
        end else if (done) begin
            state_d = EMPTY;
            out_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q   <= '0;
            sec_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sec_q   <= sec_d;
        end
    end

`ifdef NIBBLE_PARITY_EN
    logic par_q;
    always_ff @(posedge clk)
        par_q <= reset ? 1'b0 : ^out_d;
    assign out_par = par_q;
`endif

    assign out       = out_q;
    assign out_valid = state_q != EMPTY;
    assign out_last  = state_q == SECOND;

    nibble_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (done),
        .cnt   (byte_cnt)
    );
endmodule

// File: tb/tb_nibble_unpacker.sv
// tb_nibble_unpacker: directed self-checking bench for nibble_unpacker (default and CNT_W=2 instances).
module tb_nibble_unpacker;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic       swap_en, in_valid, out_ready;
    logic       in_ready, out_valid, out_last;
    logic [3:0] out;
    logic [7:0] byte_cnt;
    logic       in_ready2, out_valid2, out_last2;
    logic [3:0] out2;
    logic [1:0] byte_cnt2;
`ifdef NIBBLE_PARITY_EN
    logic       out_par, out_par2;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_unpacker dut (
        .clk(clk), .reset(reset), .in(in), .swap_en(swap_en), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last),
`ifdef NIBBLE_PARITY_EN
        .out_par(out_par),
`endif
        .byte_cnt(byte_cnt)
    );

    nibble_unpacker #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in(in), .swap_en(swap_en), .in_valid(in_valid),
        .in_ready(in_ready2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_last(out_last2),
`ifdef NIBBLE_PARITY_EN
        .out_par(out_par2),
`endif
        .byte_cnt(byte_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in = '0; swap_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1 chk("ready_in_reset", 32'(in_ready), 0);
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_cnt", 32'(byte_cnt), 0);
        chk("rst_ready", 32'(in_ready), 1);
`ifdef NIBBLE_PARITY_EN
        chk("rst_par", 32'(out_par), 0);
`endif
        // 0x71 unswapped
        in = 8'h71; swap_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("a_n1", 32'(out), 32'h7);
        chk("a_n1_valid", 32'(out_valid), 1);
        chk("a_n1_last", 32'(out_last), 0);
        chk("a_n1_ready", 32'(in_ready), 0);
        cyc();
        chk("a_n2", 32'(out), 32'h1);
        chk("a_n2_last", 32'(out_last), 1);
        cyc();
        chk("a_idle_valid", 32'(out_valid), 0);
        chk("a_cnt", 32'(byte_cnt), 1);
        // 0x71 swapped, swap_en toggled mid-byte
        in = 8'h71; swap_en = 1'b1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0; swap_en = 1'b0;
        chk("b_n1", 32'(out), 32'h1);
        cyc();
        chk("b_n2", 32'(out), 32'h7);
        chk("b_n2_last", 32'(out_last), 1);
        cyc();
        chk("b_cnt", 32'(byte_cnt), 2);
        // 0xB4 with 3 cycles of backpressure
        in = 8'hB4; swap_en = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0; in = 8'hFF; swap_en = 1'b1;
        chk("c_n1", 32'(out), 32'hB);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("c_hold_out", 32'(out), 32'hB);
            chk("c_hold_ready", 32'(in_ready), 0);
            chk("c_hold_last", 32'(out_last), 0);
        end
        out_ready = 1'b1;
        cyc();
        chk("c_n2", 32'(out), 32'h4);
        chk("c_n2_last", 32'(out_last), 1);
        cyc();
        chk("c_cnt", 32'(byte_cnt), 3);
        // back-to-back 0xC3, 0xF0
        in = 8'hC3; swap_en = 1'b0; in_valid = 1'b1;
        cyc();
        in = 8'hF0;
        chk("d_n1", 32'(out), 32'hC);
        cyc();
        chk("d_n2", 32'(out), 32'h3);
        chk("d_reload_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        chk("d_n3", 32'(out), 32'hF);
        chk("d_n3_last", 32'(out_last), 0);
        chk("d_cnt_mid", 32'(byte_cnt), 4);
        cyc();
        chk("d_n4", 32'(out), 32'h0);
        chk("d_n4_last", 32'(out_last), 1);
        cyc();
        chk("d_cnt", 32'(byte_cnt), 5);
        chk("d_cnt_wrap", 32'(byte_cnt2), 1);
        chk("d_idle_valid", 32'(out_valid), 0);
        // reset mid-byte
        in = 8'hA5; swap_en = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("e_n1", 32'(out), 32'hA);
        reset = 1'b1;
        #1 chk("e_ready_in_reset", 32'(in_ready), 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("e_valid", 32'(out_valid), 0);
        chk("e_out", 32'(out), 0);
        chk("e_cnt", 32'(byte_cnt), 0);
        chk("e_cnt2", 32'(byte_cnt2), 0);
        in = 8'h3C; swap_en = 1'b1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("f_n1", 32'(out), 32'hC);
`ifdef NIBBLE_PARITY_EN
        chk("f_par1", 32'(out_par), 0);
`endif
        cyc();
        chk("f_n2", 32'(out), 32'h3);
`ifdef NIBBLE_PARITY_EN
        chk("f_par2", 32'(out_par), 0);
`endif
        cyc();
        in = 8'h70; swap_en = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("g_n1", 32'(out), 32'h7);
`ifdef NIBBLE_PARITY_EN
        chk("g_par1", 32'(out_par), 1);
`endif
        cyc();
        chk("g_n2", 32'(out), 32'h0);
        cyc();
        chk("g_cnt", 32'(byte_cnt), 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
